// File: rtl/config_sequencer.sv
// rtl/config_sequencer.sv - FIFO-buffered broadcaster of (addr, data) configuration writes to pe_tile matchers
module config_sequencer #(
    parameter int          FIFO_DEPTH  = 4,
    parameter int          HOLD_CYCLES = 1,
    parameter logic [31:0] IDLE_ADDR   = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic [31:0] config_addr,
    output logic [31:0] config_data,
    output logic        config_busy,
    output logic        config_done,
    output logic [15:0] write_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_HOLD,
        S_DONE
    } state_t;

    // Word FIFO: {last, addr, data}
    logic [64:0]   mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   wr_ptr_vis;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          full_q;
    logic          push;
    logic          pop;
    logic          avail;
    logic [64:0]   head;
    logic          head_last;
    logic [31:0]   head_addr;
    logic [31:0]   head_data;

    assign in_ready   = !full_q && !reset;
    assign push       = in_valid && in_ready;
    assign count      = wr_ptr - rd_ptr;
    assign count_next = count + (AW+1)'(push) - (AW+1)'(pop);
    // The FSM sees entries through a one-cycle-delayed write pointer
    assign avail      = (wr_ptr_vis != rd_ptr);
    assign head       = mem[rd_ptr[AW-1:0]];
    assign head_last  = head[64];
    assign head_addr  = head[63:32];
    assign head_data  = head[31:0];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {in_last, in_addr, in_data};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            wr_ptr_vis <= '0;
            rd_ptr     <= '0;
            full_q     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            wr_ptr_vis <= wr_ptr;
            full_q     <= (count_next == (AW+1)'(FIFO_DEPTH));
        end
    end

    state_t        state_q;
    state_t        state_d;
    logic          last_q;
    logic [HW-1:0] hold_cnt_q;
    logic          hold_end;
    logic          load;

    assign hold_end = (hold_cnt_q == HOLD_LAST);

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        load    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (avail) begin
                    pop = 1'b1;
                end
            end
            S_WRITE: begin
                if (HOLD_CYCLES > 0) begin
                    state_d = S_HOLD;
                end else if (last_q) begin
                    state_d = S_DONE;
                end else if (avail) begin
                    pop = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HOLD: begin
                if (hold_end) begin
                    if (last_q) begin
                        state_d = S_DONE;
                    end else if (avail) begin
                        pop = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Words carrying the idle address are consumed without a bus write
        if (pop) begin
            if (head_addr != IDLE_ADDR) begin
                state_d = S_WRITE;
                load    = 1'b1;
            end else begin
                state_d = head_last ? S_DONE : S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            config_addr <= IDLE_ADDR;
            config_data <= '0;
            last_q      <= 1'b0;
            hold_cnt_q  <= '0;
            write_count <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                config_addr <= head_addr;
                config_data <= head_data;
                last_q      <= head_last;
                write_count <= write_count + 16'd1;
            end else begin
                config_addr <= IDLE_ADDR;
            end
            if (state_q == S_HOLD) begin
                hold_cnt_q <= hold_cnt_q + 1'b1;
            end else begin
                hold_cnt_q <= '0;
            end
        end
    end

    assign config_done = (state_q == S_DONE);
    assign config_busy = (count != '0) || (state_q != S_IDLE);

endmodule

// File: tb/tb_config_sequencer.sv
// tb/tb_config_sequencer.sv - scoreboard bench for config_sequencer with HOLD_CYCLES=1 and HOLD_CYCLES=0 instances
module tb_config_sequencer;

    localparam logic [31:0] IDLE = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic        a_valid, a_ready, a_last, a_busy, a_done;
    logic [31:0] a_addr, a_data, a_cfg_addr, a_cfg_data;
    logic [15:0] a_wc;
    logic        b_valid, b_ready, b_last, b_busy, b_done;
    logic [31:0] b_addr, b_data, b_cfg_addr, b_cfg_data;
    logic [15:0] b_wc;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    bit          bp_seen;
    bit          b_sb_en  = 1'b1;
    logic [63:0] q0[$];
    logic [63:0] q1[$];
    int          a_wr_t[$];
    int          a_done_t[$];
    int          b_wr_t[$];
    int          b_done_t[$];

    config_sequencer #(.FIFO_DEPTH(4), .HOLD_CYCLES(1), .IDLE_ADDR(IDLE)) u_a (
        .clk(clk), .reset(rst_a), .in_valid(a_valid), .in_ready(a_ready),
        .in_addr(a_addr), .in_data(a_data), .in_last(a_last),
        .config_addr(a_cfg_addr), .config_data(a_cfg_data), .config_busy(a_busy),
        .config_done(a_done), .write_count(a_wc)
    );

    config_sequencer #(.FIFO_DEPTH(4), .HOLD_CYCLES(0), .IDLE_ADDR(IDLE)) u_b (
        .clk(clk), .reset(rst_b), .in_valid(b_valid), .in_ready(b_ready),
        .in_addr(b_addr), .in_data(b_data), .in_last(b_last),
        .config_addr(b_cfg_addr), .config_data(b_cfg_data), .config_busy(b_busy),
        .config_done(b_done), .write_count(b_wc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (a_cfg_addr !== IDLE) begin
            a_wr_t.push_back(cyc);
            if (q0.size() == 0) check("a_unexpected_write", {32'h0, a_cfg_addr}, {32'h0, IDLE});
            else check("a_word", {a_cfg_addr, a_cfg_data}, q0.pop_front());
        end
        if (a_done === 1'b1) a_done_t.push_back(cyc);
    end

    always @(negedge clk) begin
        if (b_cfg_addr !== IDLE) begin
            b_wr_t.push_back(cyc);
            if (b_sb_en) begin
                if (q1.size() == 0) check("b_unexpected_write", {32'h0, b_cfg_addr}, {32'h0, IDLE});
                else check("b_word", {b_cfg_addr, b_cfg_data}, q1.pop_front());
            end
        end
        if (b_done === 1'b1) b_done_t.push_back(cyc);
    end

    task automatic push_a(input logic [31:0] ad, input logic [31:0] dd, input logic l, input bit track);
        int t = 0;
        a_valid = 1'b1; a_addr = ad; a_data = dd; a_last = l;
        while (a_ready !== 1'b1 && t < 50) begin
            bp_seen = 1'b1;
            @(negedge clk);
            t++;
        end
        check("a_push_ready", {63'h0, a_ready}, 64'h1);
        if (track) q0.push_back({ad, dd});
        @(negedge clk);
        a_valid = 1'b0;
    endtask

    task automatic push_b(input logic [31:0] ad, input logic [31:0] dd, input logic l, input bit track);
        int t = 0;
        b_valid = 1'b1; b_addr = ad; b_data = dd; b_last = l;
        while (b_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (track) begin
            check("b_push_ready", {63'h0, b_ready}, 64'h1);
            q1.push_back({ad, dd});
        end
        @(negedge clk);
        b_valid = 1'b0;
    endtask

    task automatic wait_done_a();
        int t = 0;
        while (a_done !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("a_done_seen", {63'h0, a_done}, 64'h1);
    endtask

    task automatic wait_done_b();
        int t = 0;
        while (b_done !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("b_done_seen", {63'h0, b_done}, 64'h1);
    endtask

    initial begin
        int sw, sd, t;
        rst_a = 1'b1; rst_b = 1'b1;
        a_valid = 1'b0; a_addr = '0; a_data = '0; a_last = 1'b0;
        b_valid = 1'b0; b_addr = '0; b_data = '0; b_last = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_addr", a_cfg_addr, IDLE);
        check("rst_data", a_cfg_data, 0);
        check("rst_done", a_done, 0);
        check("rst_wc", a_wc, 0);
        check("rst_ready_low", a_ready, 0);
        check("rst_busy", a_busy, 0);
        check("rst_b_ready_low", b_ready, 0);
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);
        check("post_rst_ready", a_ready, 1);

        // T1: single write, bus in cycle 2, hold in 3, done in 4
        push_a(32'h0001_0001, 32'h0000_00A5, 1'b1, 1'b1);
        check("t1_c0_addr", a_cfg_addr, IDLE);
        check("t1_c0_busy", a_busy, 1);
        @(negedge clk);
        check("t1_c1_addr", a_cfg_addr, IDLE);
        @(negedge clk);
        check("t1_c2_addr", a_cfg_addr, 32'h0001_0001);
        check("t1_c2_data", a_cfg_data, 32'h0000_00A5);
        check("t1_c2_wc", a_wc, 1);
        @(negedge clk);
        check("t1_c3_addr", a_cfg_addr, IDLE);
        check("t1_c3_data_held", a_cfg_data, 32'h0000_00A5);
        check("t1_c3_done", a_done, 0);
        @(negedge clk);
        check("t1_c4_done", a_done, 1);
        @(negedge clk);
        check("t1_c5_done", a_done, 0);
        check("t1_c5_busy", a_busy, 0);

        // T2: 8-word burst with backpressure, writes two cycles apart
        sw = a_wr_t.size(); sd = a_done_t.size(); bp_seen = 1'b0;
        for (int i = 0; i < 8; i++)
            push_a({16'h0002, 16'(i)}, 32'hB000_0000 + 32'(i), i == 7, 1'b1);
        wait_done_a();
        @(negedge clk);
        check("t2_backpressure", {63'h0, bp_seen}, 1);
        check("t2_writes", a_wr_t.size() - sw, 8);
        for (int i = 1; i < 8; i++)
            check("t2_gap", a_wr_t[sw+i] - a_wr_t[sw+i-1], 2);
        check("t2_done_pos", a_done_t[a_done_t.size()-1] - a_wr_t[a_wr_t.size()-1], 2);
        check("t2_done_count", a_done_t.size() - sd, 1);
        check("t2_wc", a_wc, 9);
        check("t2_sb_empty", q0.size(), 0);

        // T4: idle-address word with last is dropped but still signals done
        sw = a_wr_t.size(); sd = a_done_t.size();
        push_a(IDLE, 32'h1234_5678, 1'b1, 1'b0);
        wait_done_a();
        repeat (3) @(negedge clk);
        check("t4_wc", a_wc, 9);
        check("t4_no_write", a_wr_t.size() - sw, 0);
        check("t4_done_count", a_done_t.size() - sd, 1);

        // T5: reset while in WRITE with three words queued
        for (int i = 0; i < 5; i++)
            push_a({16'h0003, 16'(i)}, 32'hC000_0000 + 32'(i), i == 4, 1'b1);
        t = 0;
        while (a_cfg_addr !== 32'h0003_0001 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("t5_in_write", a_cfg_addr, 32'h0003_0001);
        #2 rst_a = 1'b1;
        #1;
        check("t5_async_addr", a_cfg_addr, IDLE);
        check("t5_rst_ready", a_ready, 0);
        check("t5_rst_wc", a_wc, 0);
        check("t5_rst_done", a_done, 0);
        q0.delete();
        @(negedge clk);
        rst_a = 1'b0;
        sw = a_wr_t.size(); sd = a_done_t.size();
        @(negedge clk);
        check("t5_busy", a_busy, 0);
        check("t5_wc", a_wc, 0);
        check("t5_ready", a_ready, 1);
        repeat (8) @(negedge clk);
        check("t5_no_writes", a_wr_t.size() - sw, 0);
        check("t5_no_done", a_done_t.size() - sd, 0);

        // T3: back-to-back writes with HOLD_CYCLES=0
        sw = b_wr_t.size(); sd = b_done_t.size();
        for (int i = 0; i < 4; i++)
            push_b({16'h0004, 16'(i)}, 32'hD000_0000 + 32'(i), i == 3, 1'b1);
        wait_done_b();
        @(negedge clk);
        check("t3_writes", b_wr_t.size() - sw, 4);
        for (int i = 1; i < 4; i++)
            check("t3_gap", b_wr_t[sw+i] - b_wr_t[sw+i-1], 1);
        check("t3_done_pos", b_done_t[b_done_t.size()-1] - b_wr_t[b_wr_t.size()-1], 1);
        check("t3_done_count", b_done_t.size() - sd, 1);
        check("t3_wc", b_wc, 4);

        // T6: 65536 writes wrap the counter to zero
        rst_b = 1'b1;
        @(negedge clk);
        check("t6_rst_wc", b_wc, 0);
        rst_b = 1'b0;
        @(negedge clk);
        b_sb_en = 1'b0;
        sw = b_wr_t.size(); sd = b_done_t.size();
        for (int i = 0; i < 65536; i++) begin
            b_valid = 1'b1; b_addr = {16'h0005, i[15:0]}; b_data = i; b_last = (i == 65535);
            t = 0;
            while (b_ready !== 1'b1 && t < 50) begin
                @(negedge clk);
                t++;
            end
            @(negedge clk);
        end
        b_valid = 1'b0;
        wait_done_b();
        @(negedge clk);
        check("t6_wc_wrapped", b_wc, 0);
        check("t6_writes", b_wr_t.size() - sw, 65536);
        check("t6_done_count", b_done_t.size() - sd, 1);
        b_sb_en = 1'b1;
        push_b(32'h0006_0000, 32'hDEAD_BEEF, 1'b1, 1'b1);
        wait_done_b();
        @(negedge clk);
        check("t6_wc_after", b_wc, 1);
        check("t6_sb_empty", q1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
